// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the store buffer.
// Holds the datapath width, the one-hot access-size encodings and the
// store-buffer entry payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // One-hot access sizes as presented by execute
  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  // One buffered store: word address, lane-replicated data, byte enables
  typedef struct packed {
    logic [XLEN-3:0] wadr;
    logic [XLEN-1:0] data;
    logic [3:0]      be;
  } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store alignment: replicates the store payload across byte
// lanes, builds byte enables from the low address bits and flags illegal
// alignment or a malformed size code.
// Ports:
//   i_adr_lo     - effective address bits [1:0]
//   i_size       - one-hot access size (byte/half/word)
//   i_data       - rs2 store data, payload in the low bits
//   o_data       - lane-replicated data for the 32-bit bus
//   o_be         - byte enables
//   o_misaligned - store must be dropped
module store_align
  import riscv_pkg::*;
(
  input  logic [1:0]      i_adr_lo,
  input  logic [2:0]      i_size,
  input  logic [XLEN-1:0] i_data,
  output logic [XLEN-1:0] o_data,
  output logic [3:0]      o_be,
  output logic            o_misaligned
);

  always_comb begin
    o_data       = '0;
    o_be         = 4'b0000;
    o_misaligned = 1'b1;
    case (i_size)
      SIZE_B: begin
        o_data       = {4{i_data[7:0]}};
        o_be         = 4'b0001 << i_adr_lo;
        o_misaligned = 1'b0;
      end
      SIZE_H: begin
        o_data       = {2{i_data[15:0]}};
        o_be         = 4'b0011 << i_adr_lo;
        o_misaligned = i_adr_lo[0];
      end
      SIZE_W: begin
        o_data       = i_data;
        o_be         = 4'b1111;
        o_misaligned = |i_adr_lo;
      end
      // zero or multi-hot size codes are treated as misaligned
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between execute and the data-memory write port. Computes the
// effective address, aligns data/byte enables, queues stores in a DEPTH-entry
// FIFO and drains them in program order over a req/ack handshake.
// Optional feature macro: STORE_BUF_FWD_EN adds ld_adr_i/ld_hit_o, a
// combinational word-address match of a load against pending stores.
// Ports:
//   clk, reset_n                  - clock, async active-low reset
//   st_valid_i / st_ready_o       - store handshake from execute
//   rs1_data_i, immediat_i        - base and offset of the effective address
//   store_data_i, access_size_i   - store payload and one-hot size
//   misalign_o                    - pulse: previous accepted store was dropped
//   mem_req_o / mem_ack_i         - drain handshake to data memory
//   mem_adr_o, mem_data_o, mem_be_o - head entry
//   empty_o                       - no buffered stores
//   ld_adr_i, ld_hit_o            - load overlap check (STORE_BUF_FWD_EN)
module store_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            st_valid_i,
  output logic            st_ready_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] immediat_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic            misalign_o,
  output logic            mem_req_o,
  input  logic            mem_ack_i,
  output logic [XLEN-1:0] mem_adr_o,
  output logic [XLEN-1:0] mem_data_o,
  output logic [3:0]      mem_be_o,
`ifdef STORE_BUF_FWD_EN
  input  logic [XLEN-1:0] ld_adr_i,
  output logic            ld_hit_o,
`endif
  output logic            empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  sb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_misalign;

  logic [XLEN-1:0] w_adr;
  logic [XLEN-1:0] w_al_data;
  logic [3:0]      w_al_be;
  logic            w_al_mis;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  sb_entry_t       w_new;
  sb_entry_t       w_head;

  // Effective address wraps modulo 2^XLEN
  assign w_adr = rs1_data_i + immediat_i;

  store_align u_align (
    .i_adr_lo     (w_adr[1:0]),
    .i_size       (access_size_i),
    .i_data       (store_data_i),
    .o_data       (w_al_data),
    .o_be         (w_al_be),
    .o_misaligned (w_al_mis)
  );

  assign st_ready_o = (r_count != CW'(DEPTH));
  assign mem_req_o  = (r_count != '0);
  assign empty_o    = (r_count == '0);
  assign misalign_o = r_misalign;

  // A misaligned store completes its handshake but is never written
  assign w_accept = st_valid_i & st_ready_o;
  assign w_push   = w_accept & ~w_al_mis;
  assign w_pop    = mem_ack_i & mem_req_o;

  assign w_new.wadr = w_adr[XLEN-1:2];
  assign w_new.data = w_al_data;
  assign w_new.be   = w_al_be;

  assign w_head     = r_mem[r_rd_ptr];
  assign mem_adr_o  = {w_head.wadr, 2'b00};
  assign mem_data_o = w_head.data;
  assign mem_be_o   = w_head.be;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept & w_al_mis;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] w_off;

  // Entry i is valid when its distance from the head is below the count;
  // the store being enqueued this cycle is not yet in the array
  always_comb begin
    ld_hit_o = 1'b0;
    w_off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rd_ptr;
      if ((CW'(w_off) < r_count) &&
          (((ld_adr_i ^ {r_mem[i].wadr, 2'b00}) & ~XLEN'(3)) == '0))
        ld_hit_o = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        st_valid_i = 1'b0;
  logic        st_ready_o;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] immediat_i = '0;
  logic [31:0] store_data_i = '0;
  logic [2:0]  access_size_i = 3'b000;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_be_o;
  logic        empty_o;
`ifdef STORE_BUF_FWD_EN
  logic [31:0] ld_adr_i = '0;
  logic        ld_hit_o;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  bit   exp_mis = 1'b0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .st_valid_i    (st_valid_i),
    .st_ready_o    (st_ready_o),
    .rs1_data_i    (rs1_data_i),
    .immediat_i    (immediat_i),
    .store_data_i  (store_data_i),
    .access_size_i (access_size_i),
    .misalign_o    (misalign_o),
    .mem_req_o     (mem_req_o),
    .mem_ack_i     (mem_ack_i),
    .mem_adr_o     (mem_adr_o),
    .mem_data_o    (mem_data_o),
    .mem_be_o      (mem_be_o),
`ifdef STORE_BUF_FWD_EN
    .ld_adr_i      (ld_adr_i),
    .ld_hit_o      (ld_hit_o),
`endif
    .empty_o       (empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model state
  task automatic check_all(input string tag);
    chk({tag, ".req"},   32'(mem_req_o),  32'(q.size() != 0));
    chk({tag, ".ready"}, 32'(st_ready_o), 32'(q.size() < DEPTH));
    chk({tag, ".empty"}, 32'(empty_o),    32'(q.size() == 0));
    chk({tag, ".mis"},   32'(misalign_o), 32'(exp_mis));
    if (q.size() != 0) begin
      chk({tag, ".adr"},  mem_adr_o,       q[0].adr);
      chk({tag, ".data"}, mem_data_o,      q[0].data);
      chk({tag, ".be"},   32'(mem_be_o),   32'(q[0].be));
    end
`ifdef STORE_BUF_FWD_EN
    begin
      bit hit = 1'b0;
      foreach (q[i]) if ((q[i].adr >> 2) == (ld_adr_i >> 2)) hit = 1'b1;
      chk({tag, ".ldhit"}, 32'(ld_hit_o), 32'(hit));
    end
`endif
  endtask

  // One clock cycle: drive inputs, predict from the rules, advance, compare
  task automatic step(input string tag, input logic v, input logic [31:0] rs1,
                      input logic [31:0] imm, input logic [31:0] d,
                      input logic [2:0] sz, input logic ack);
    int unsigned nbytes;
    logic [31:0] ea;
    bit ok, accept;
    exp_t e;
    st_valid_i    = v;
    rs1_data_i    = rs1;
    immediat_i    = imm;
    store_data_i  = d;
    access_size_i = sz;
    mem_ack_i     = ack;
    ea = rs1 + imm;
    case (sz)
      3'b001:  nbytes = 1;
      3'b010:  nbytes = 2;
      3'b100:  nbytes = 4;
      default: nbytes = 0;
    endcase
    ok = (nbytes != 0) && ((ea % nbytes) == 0);
    e.adr = ea & 32'hFFFF_FFFC;
    case (nbytes)
      1:       e.data = {24'h0, d[7:0]} * 32'h0101_0101;
      2:       e.data = {16'h0, d[15:0]} * 32'h0001_0001;
      default: e.data = d;
    endcase
    e.be = 4'(((32'd1 << nbytes) - 1) << (ea % 4));
    accept = v && (q.size() < DEPTH);
    @(posedge clk);
    if (ack && q.size() != 0) void'(q.pop_front());
    if (accept && ok) q.push_back(e);
    exp_mis = accept && !ok;
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic ack);
    step(tag, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, ack);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.req",   32'(mem_req_o),  32'd0);
    chk("rst.ready", 32'(st_ready_o), 32'd1);
    chk("rst.empty", 32'(empty_o),    32'd1);
    chk("rst.mis",   32'(misalign_o), 32'd0);
    chk("rst.adr",   mem_adr_o,       32'h0);
    chk("rst.data",  mem_data_o,      32'h0);
    chk("rst.be",    32'(mem_be_o),   32'h0);
`ifdef STORE_BUF_FWD_EN
    chk("rst.ldhit", 32'(ld_hit_o),   32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Byte store, visible the cycle after acceptance
    step("byte", 1'b1, 32'h1000, 32'd3, 32'h0000_00A5, 3'b001, 1'b0);
    chk("byte.adr_const",  mem_adr_o,     32'h0000_1000);
    chk("byte.data_const", mem_data_o,    32'hA5A5_A5A5);
    chk("byte.be_const",   32'(mem_be_o), 32'h8);
    idle("byte.drain", 1'b1);

    // Half store and its misaligned variant
    step("half", 1'b1, 32'h2000, 32'd2, 32'h0000_BEEF, 3'b010, 1'b0);
    chk("half.data_const", mem_data_o,    32'hBEEF_BEEF);
    chk("half.be_const",   32'(mem_be_o), 32'hC);
    idle("half.drain", 1'b1);
    step("halfmis", 1'b1, 32'h2000, 32'd1, 32'h0000_BEEF, 3'b010, 1'b0);
    chk("halfmis.pulse", 32'(misalign_o), 32'd1);
    idle("halfmis.after", 1'b0);
    chk("halfmis.clear", 32'(misalign_o), 32'd0);
    step("wordmis", 1'b1, 32'h2000, 32'd2, 32'h1234_5678, 3'b100, 1'b0);
    step("badsize", 1'b1, 32'h2000, 32'd0, 32'h1234_5678, 3'b011, 1'b0);
    step("zerosize", 1'b1, 32'h2000, 32'd0, 32'h1234_5678, 3'b000, 1'b0);
    idle("ack_empty", 1'b1);

    // Fill with no acks, one extra store is refused
    for (int i = 0; i < 5; i++)
      step("fill", 1'b1, 32'h4000 + 32'(i * 16), 32'd0, 32'hC0DE_0000 + 32'(i), 3'b100, 1'b0);
    chk("fill.ready_const", 32'(st_ready_o), 32'd0);
    idle("hold", 1'b0);
    idle("hold", 1'b0);
    // Full and acked with a store offered: not taken this cycle
    step("fullack", 1'b1, 32'h5000, 32'd0, 32'h5555_5555, 3'b100, 1'b1);
    for (int i = 0; i < 4; i++) idle("drain", 1'b1);

    // Streaming with ack tied high, including address wrap
    step("wrap", 1'b1, 32'hFFFF_FFFC, 32'd8, 32'hDEAD_BEEF, 3'b100, 1'b1);
    chk("wrap.adr_const", mem_adr_o, 32'h0000_0004);
    for (int i = 0; i < 6; i++)
      step("stream", 1'b1, 32'h6000, 32'(i), 32'h1111_1111 * 32'(i), 3'b001, 1'b1);
    idle("stream.end", 1'b1);

`ifdef STORE_BUF_FWD_EN
    ld_adr_i = 32'h3006;
    step("fwd.push", 1'b1, 32'h3000, 32'd4, 32'hFEED_F00D, 3'b100, 1'b0);
    chk("fwd.hit_const", 32'(ld_hit_o), 32'd1);
    ld_adr_i = 32'h3008;
    #1;
    chk("fwd.miss_const", 32'(ld_hit_o), 32'd0);
    ld_adr_i = 32'h3004;
    idle("fwd.ack", 1'b1);
    chk("fwd.gone_const", 32'(ld_hit_o), 32'd0);
`endif

    // Reset with three entries pending
    for (int i = 0; i < 3; i++)
      step("prerst", 1'b1, 32'h7000, 32'(i * 4), 32'hABCD_0000 + 32'(i), 3'b100, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    exp_mis = 1'b0;
    chk("midrst.req",   32'(mem_req_o),  32'd0);
    chk("midrst.empty", 32'(empty_o),    32'd1);
    chk("midrst.ready", 32'(st_ready_o), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    idle("postrst", 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  sz;
      logic [31:0] imm;
      case ($urandom_range(0, 4))
        0:       sz = 3'b001;
        1:       sz = 3'b010;
        2, 3:    sz = 3'b100;
        default: sz = 3'($urandom);
      endcase
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7) * 4);
      imm = imm + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
`ifdef STORE_BUF_FWD_EN
      ld_adr_i = (q.size() != 0 && $urandom_range(0, 1) == 1) ?
                 q[$urandom_range(0, q.size() - 1)].adr + 32'($urandom_range(0, 3)) : $urandom;
`endif
      step("rand", ($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC, imm,
           $urandom, sz, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) idle("final", 1'b1);
    chk("final.empty_const", 32'(empty_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
